// File: rtl/dmem_arbiter.sv
// Purpose: two-requester round-robin arbiter/sequencer for the single-port data_mem.
// Latency: req seen in IDLE -> ACCESS next cycle -> ack one cycle later (req-to-ack 2 cycles, 3 cycles/txn).
// Backpressure: requesters hold req until their ack; reqs are ignored outside IDLE.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*   per-requester access request (0 = CPU, 1 = debug/DMA)
//   ack*/err*/rdata*        per-requester completion pulse, misalignment flag, read data
//   MemRead/MemWrite/mem_addr/mem_data   data_mem port (mem_data bidirectional)
//   busy                    high while in ACCESS or ACK
module dmem_arbiter #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [DW-1:0] addr0,
    input  logic [DW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [DW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data,
    output logic          busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    logic [1:0]    state;
    logic          ptr;        // requester that wins the next tie
    logic          win;        // requester owning the current transaction
    logic          lat_we;
    logic          lat_err;
    logic [DW-1:0] lat_wdata;

    // Winner selection: a lone request always wins, a tie goes to ptr.
    logic          grant_vld;
    logic          grant_id;
    logic          sel_we;
    logic          sel_mis;
    logic [DW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_comb begin
        grant_vld = req0 | req1;
        grant_id  = (req0 & req1) ? ptr : req1;
        sel_we    = grant_id ? we1    : we0;
        sel_addr  = grant_id ? addr1  : addr0;
        sel_wdata = grant_id ? wdata1 : wdata0;
        sel_mis   = |sel_addr[2:0];
    end

    // Only drive the shared bus in the write cycle; memory drives it on reads.
    assign mem_data = MemWrite ? lat_wdata : {DW{1'bz}};

    // busy is a decode of the state flops, so there is still no path from req.
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= 1'b0;
            win       <= 1'b0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        win       <= grant_id;
                        ptr       <= ~grant_id;
                        lat_we    <= sel_we;
                        lat_err   <= sel_mis;
                        lat_wdata <= sel_wdata;
                        // Enables for the ACCESS cycle are registered here;
                        // a misaligned access never touches memory.
                        MemRead   <= ~sel_mis & ~sel_we;
                        MemWrite  <= ~sel_mis &  sel_we;
                        mem_addr  <= sel_mis ? '0 : sel_addr;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    mem_addr <= '0;
                    // Only the winner's ack/err/rdata are touched.
                    if (win) begin
                        ack1 <= 1'b1;
                        err1 <= lat_err;
                        if (lat_err)
                            rdata1 <= '0;
                        else if (!lat_we)
                            rdata1 <= mem_data;
                    end else begin
                        ack0 <= 1'b1;
                        err0 <= lat_err;
                        if (lat_err)
                            rdata0 <= '0;
                        else if (!lat_we)
                            rdata0 <= mem_data;
                    end
                    state <= S_ACK;
                end
                S_ACK: begin
                    if (win) begin
                        ack1 <= 1'b0;
                        err1 <= 1'b0;
                    end else begin
                        ack0 <= 1'b0;
                        err0 <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: directed self-checking bench for dmem_arbiter with a small word-addressed memory model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: requests held until the matching ack, then dropped.
module tb_dmem_arbiter;

    logic        tb_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [63:0] addr0 = '0, addr1 = '0;
    logic [63:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1;
    logic [63:0] rdata0, rdata1;
    logic        MemRead, MemWrite;
    logic [63:0] mem_addr;
    wire  [63:0] mem_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 tb_clk = ~tb_clk;

    dmem_arbiter #(.DW(64)) dut (
        .clk      (tb_clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .err0     (err0),
        .err1     (err1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy)
    );

    // Memory model: 32 words, preloaded with 8 at byte 64 and 16 at byte 128.
    logic [63:0] mem [0:31];
    logic        preload = 1'b1;
    logic [63:0] rd_word;

    assign rd_word  = mem[mem_addr[7:3]];
    assign mem_data = MemRead ? rd_word : 64'bz;

    always @(posedge tb_clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 64'd0;
            mem[8]  <= 64'd8;
            mem[16] <= 64'd16;
        end else if (MemWrite) begin
            mem[mem_addr[7:3]] <= mem_data;
        end
    end

    // Pulse monitors.
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    always @(negedge tb_clk) begin
        if (MemRead)             rd_cnt++;
        if (MemWrite)            wr_cnt++;
        if (MemRead && MemWrite) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    // One complete transaction from a single requester, checked cycle by cycle.
    task automatic do_txn(input logic id, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic exp_err,
                          input logic [63:0] exp_rdata, input logic [63:0] exp_other);
        int wr0, rd0;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        if (id) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
        else    begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
        tick();  // ACCESS
        check("acc_busy", {63'd0, busy}, 64'd1);
        check("acc_rd",   {63'd0, MemRead},  {63'd0, ~exp_err & ~we});
        check("acc_wr",   {63'd0, MemWrite}, {63'd0, ~exp_err &  we});
        if (!exp_err) check("acc_addr", mem_addr, addr);
        check("acc_noack", {62'd0, ack1, ack0}, 64'd0);
        tick();  // ACK
        check("ack_vec", {62'd0, ack1, ack0}, id ? 64'd2 : 64'd1);
        check("ack_err", {63'd0, id ? err1 : err0}, {63'd0, exp_err});
        check("ack_rdata", id ? rdata1 : rdata0, exp_rdata);
        check("ack_other", id ? rdata0 : rdata1, exp_other);
        check("ack_nomem", {63'd0, MemRead | MemWrite}, 64'd0);
        check("wr_pulses", 64'(wr_cnt - wr0), (we && !exp_err) ? 64'd1 : 64'd0);
        check("rd_pulses", 64'(rd_cnt - rd0), (!we && !exp_err) ? 64'd1 : 64'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();  // back in IDLE
        check("idle_ack",  {62'd0, ack1, ack0}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_addr", mem_addr, 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- Reset values ----
        rst_n = 1'b0;
        tick(); tick();
        preload = 1'b0;
        rst_n   = 1'b1;
        #1;
        check("rst_ack",   {60'd0, ack1, ack0, err1, err0}, 64'd0);
        check("rst_rd0",   rdata0, 64'd0);
        check("rst_rd1",   rdata1, 64'd0);
        check("rst_en",    {62'd0, MemRead, MemWrite}, 64'd0);
        check("rst_addr",  mem_addr, 64'd0);
        check("rst_busy",  {63'd0, busy}, 64'd0);
        tick();
        check("rst_idle_busy", {63'd0, busy}, 64'd0);

        // ---- Round-robin, both held: ptr=0 after reset, so 0 wins first ----
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'd64;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'd128;
        for (int k = 1; k <= 11; k++) begin
            tick();
            check("rr_ack0", {63'd0, ack0}, (k == 2 || k == 8)  ? 64'd1 : 64'd0);
            check("rr_ack1", {63'd0, ack1}, (k == 5 || k == 11) ? 64'd1 : 64'd0);
            check("rr_busy", {63'd0, busy}, (k % 3 == 0) ? 64'd0 : 64'd1);
            check("rr_mrd",  {63'd0, MemRead}, (k % 3 == 1) ? 64'd1 : 64'd0);
            if (k == 2)  check("rr_rdata0", rdata0, 64'd8);
            if (k == 5)  check("rr_rdata1", rdata1, 64'd16);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("rr_end_busy", {63'd0, busy}, 64'd0);

        // ---- Single reads ----
        do_txn(1'b0, 1'b0, 64'd64,  64'd0, 1'b0, 64'd8,  64'd16);
        do_txn(1'b1, 1'b0, 64'd128, 64'd0, 1'b0, 64'd16, 64'd8);

        // ---- Write then read ----
        do_txn(1'b1, 1'b1, 64'd64, 64'd13, 1'b0, 64'd16, 64'd8);
        do_txn(1'b0, 1'b0, 64'd64, 64'd0,  1'b0, 64'd13, 64'd16);

        // ---- Misaligned write, then the word is unchanged ----
        do_txn(1'b0, 1'b1, 64'd68, 64'd55, 1'b1, 64'd0,  64'd16);
        do_txn(1'b0, 1'b0, 64'd64, 64'd0,  1'b0, 64'd13, 64'd16);

        // ---- Reset in the middle of a write ----
        req1 = 1'b1; we1 = 1'b1; addr1 = 64'd128; wdata1 = 64'd99;
        tick();  // ACCESS
        check("mid_wr_pre", {63'd0, MemWrite}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_en",   {62'd0, MemRead, MemWrite}, 64'd0);
        check("mid_busy", {63'd0, busy}, 64'd0);
        check("mid_addr", mem_addr, 64'd0);
        check("mid_rd0",  rdata0, 64'd0);
        tick();
        check("mid_noack", {62'd0, ack1, ack0}, 64'd0);
        req1 = 1'b0;
        we1  = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_ack", {62'd0, ack1, ack0}, 64'd0);
        do_txn(1'b1, 1'b0, 64'd128, 64'd0, 1'b0, 64'd16, 64'd0);

        check("never_both", 64'(both_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the shared `data_mem` block. It lets the CPU load/store path (requester 0) and the debug/DMA loader (requester 1) share the memory's single port. It registers each granted request, drives `MemRead`/`MemWrite`/address and the bidirectional data bus for exactly one cycle, then returns read data with a one-cycle acknowledge. Grants alternate round-robin, so neither requester can starve the other.

## Interface
- `DW`, `` `WORD `` (64): data and address width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`/`req1`  in  1  access request; held high until the matching ack.
- `we0`/`we1`  in  1  1 = write, 0 = read; valid while req high.
- `addr0`/`addr1`  in  DW  byte address; must be 8-byte aligned.
- `wdata0`/`wdata1`  in  DW  write data.
- `ack0`/`ack1`  out  1  one-cycle completion pulse.
- `err0`/`err1`  out  1  valid with ack; 1 = misaligned address, no memory access performed.
- `rdata0`/`rdata1`  out  DW  read data; valid from ack, held until the next ack to the same requester.
- `MemRead`  out  1  memory read enable.
- `MemWrite`  out  1  memory write enable.
- `mem_addr`  out  DW  memory address.
- `mem_data`  inout  DW  driven with latched write data only while `MemWrite`=1, otherwise `'bz`.
- `busy`  out  1  high in ACCESS and ACK.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- **IDLE**
  - If any req is high, select a winner.
  - With both requests high, the winner is the requester named by the priority pointer `ptr`.
  - With a single request high, that requester wins regardless of `ptr`.
  - On the edge: latch winner id, we, addr, wdata; set `ptr` to the non-winner; go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS** (exactly 1 cycle)
  - Aligned address (addr[2:0]=0): `mem_addr`=latched addr, `MemRead`=~we, `MemWrite`=we, `mem_data` driven when writing.
  - On the edge, a read captures `mem_data` into the winner's rdata register; a write is committed by memory.
  - Misaligned address: both enables stay 0 and the winner's err flag is set.
  - Go to ACK.
- **ACK** (exactly 1 cycle)
  - `ack` of the winner = 1 and `err` = latched error.
  - Misaligned access: `rdata` cleared to 0. Aligned write: `rdata` unchanged.
  - Go to IDLE.
- A req still high in the cycle after ACK is treated as a new request.
- `MemRead` and `MemWrite` are never both 1.
- The other requester's ack/rdata/err are never disturbed by a transaction.
- Outside ACCESS, `mem_addr` = 0 and both enables are 0.

## Timing
- Reset values: state IDLE, `ptr`=0, all ack/err=0, rdata0/rdata1=0, `MemRead`=`MemWrite`=0, `mem_addr`=0, `mem_data`=`'bz`, `busy`=0.
- Reset is asynchronous. Asserting `rst_n` mid-ACCESS forces reset values immediately.
  - A write that has not yet reached its closing edge is abandoned.
  - No ack is issued for an abandoned transaction.
- Latency: req high at edge N (state IDLE) gives ACCESS in cycle N..N+1 and ack high in cycle N+1..N+2.
- Request to ack is 2 cycles. Throughput is one transaction per 3 cycles.
- Both requesters held continuously: grants alternate 0,1,0,1…; each requester is acked every 6 cycles.
- `ack`, `err`, `rdata`, `busy`, `MemRead`, `MemWrite` and `mem_addr` are all registered, with no combinational path from req.
- A req change during ACCESS or ACK has no effect on the current transaction.

## Test plan
- **Reset values:** assert rst_n=0, then release → every output at its reset value, `mem_data` = z, `ptr`=0.
- **Single read:** memory preloaded with 8 at address 64 and 16 at 128; req0 read addr 64 → ack0 two cycles later with rdata0=8. req1 read addr 128 → ack1 with rdata1=16, and rdata0 still 8.
- **Write then read:** req1 write addr 64, wdata 13 → `MemWrite`=1 for exactly one cycle, ack1, err1=0. Then req0 read addr 64 → rdata0=13.
- **Round-robin:** req0 and req1 both held high reading 64 and 128 → acks ordered 0,1,0,1 at 3-cycle spacing. `MemRead` and `MemWrite` are never simultaneously high.
- **Misaligned:** req0 write addr 68 → no `MemRead`/`MemWrite` pulse, ack0 with err0=1 and rdata0=0. A following read of addr 64 returns the unchanged value.
- **Reset mid-access:** req1 write addr 128, wdata 99; drop rst_n during ACCESS → outputs reset immediately and no ack1. After release, a read of addr 128 returns 16.
